// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage (shift-add multiply, restoring divide).
// Optional MULDIV_FAST_MUL_EN: multiplies use a single-cycle 33x33 signed multiplier instead.
module ex_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] srca_i,
  input  logic [XLEN-1:0] srcb_i,
  input  logic [4:0]      rd_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [2:0]          r_funct3;
  logic [4:0]          r_rd;
  logic [4:0]          r_rd_out;
  logic [XLEN-1:0]     r_result;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_b;
  logic                r_neg;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_accept;
  logic                w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_neg;
  logic [XLEN-1:0]     w_a_mag, w_b_mag;
  logic                w_div0, w_ovf, w_special;
  logic [XLEN-1:0]     w_special_res;
  logic                w_fast;
  logic [XLEN-1:0]     w_fast_res;
  logic [XLEN:0]       w_mul_sum;
  logic [2*XLEN-1:0]   w_mul_next;
  logic [XLEN+1:0]     w_div_diff;
  logic [2*XLEN-1:0]   w_div_next;
  logic [2*XLEN-1:0]   w_acc_next;
  logic [2*XLEN-1:0]   w_mul_fix;
  logic [XLEN-1:0]     w_div_sel, w_div_fix, w_final;
  logic                w_last;

  // Operand decode: multiplies signed per MULH/MULHSU/MULHU, divides signed unless funct3[0].
  assign w_a_signed = funct3_i[2] ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11);
  assign w_b_signed = funct3_i[2] ? ~funct3_i[0] : ~funct3_i[1];
  assign w_a_neg    = w_a_signed & srca_i[XLEN-1];
  assign w_b_neg    = w_b_signed & srcb_i[XLEN-1];
  assign w_a_mag    = w_a_neg ? (~srca_i + 1'b1) : srca_i;
  assign w_b_mag    = w_b_neg ? (~srcb_i + 1'b1) : srcb_i;
  // REM follows the dividend's sign; everything else negates when signs differ.
  assign w_neg      = (funct3_i[2] & funct3_i[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

  assign w_div0     = funct3_i[2] && (srcb_i == '0);
  assign w_ovf      = funct3_i[2] && !funct3_i[0] &&
                      (srca_i == {1'b1, {(XLEN-1){1'b0}}}) && (srcb_i == '1);
  assign w_special  = w_div0 | w_ovf;
  assign w_special_res = w_div0 ? (funct3_i[1] ? srca_i : '1)
                                : (funct3_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN-1:0] w_fast_prod;
  assign w_fast_prod = $signed({w_a_signed & srca_i[XLEN-1], srca_i}) *
                       $signed({w_b_signed & srcb_i[XLEN-1], srcb_i});
  assign w_fast      = ~funct3_i[2];
  assign w_fast_res  = (funct3_i[1:0] == 2'b00) ? w_fast_prod[XLEN-1:0]
                                                : w_fast_prod[2*XLEN-1:XLEN];
`else
  assign w_fast      = 1'b0;
  assign w_fast_res  = '0;
`endif

  assign w_accept = (r_state == S_IDLE) && start_i && !flush_i;
  assign w_last   = (r_cnt == CNT_W'(XLEN-1));

  // Multiply step: add multiplicand into the upper half when the low bit is set, shift right.
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
  // Divide step: 33-bit partial remainder keeps the bit shifted out of the top.
  assign w_div_diff = {1'b0, r_acc[2*XLEN-1:XLEN-1]} - {2'b00, r_b};
  assign w_div_next = w_div_diff[XLEN+1] ? {r_acc[2*XLEN-2:0], 1'b0}
                                         : {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
  assign w_acc_next = r_funct3[2] ? w_div_next : w_mul_next;

  assign w_mul_fix = r_neg ? (~w_acc_next + 1'b1) : w_acc_next;
  assign w_div_sel = r_funct3[1] ? w_acc_next[2*XLEN-1:XLEN] : w_acc_next[XLEN-1:0];
  assign w_div_fix = r_neg ? (~w_div_sel + 1'b1) : w_div_sel;
  assign w_final   = r_funct3[2] ? w_div_fix
                   : ((r_funct3[1:0] == 2'b00) ? w_mul_fix[XLEN-1:0] : w_mul_fix[2*XLEN-1:XLEN]);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_next = (w_special || w_fast) ? S_DONE : S_CALC;
      S_CALC: if (w_last) w_state_next = S_DONE;
      S_DONE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (flush_i) w_state_next = S_IDLE;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_funct3 <= '0;
      r_rd     <= '0;
      r_rd_out <= '0;
      r_result <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_funct3 <= funct3_i;
        r_rd     <= rd_i;
        r_acc    <= {{XLEN{1'b0}}, w_a_mag};
        r_b      <= w_b_mag;
        r_neg    <= w_neg;
        r_cnt    <= '0;
        if (w_special) begin
          r_result <= w_special_res;
          r_rd_out <= rd_i;
        end else if (w_fast) begin
          r_result <= w_fast_res;
          r_rd_out <= rd_i;
        end
      end else if (r_state == S_CALC && !flush_i) begin
        r_acc <= w_acc_next;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_result <= w_final;
          r_rd_out <= r_rd;
        end
      end
    end
  end

  assign done_o   = (r_state == S_DONE);
  assign busy_o   = (r_state == S_CALC);
  assign stall_o  = start_i & ~done_o;
  assign result_o = r_result;
  assign rd_o     = r_rd_out;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomized self-checking bench for ex_muldiv_unit against an arithmetic reference model.
// Honours MULDIV_FAST_MUL_EN for multiply latency.
module tb_ex_muldiv_unit;
  logic        CLK = 1'b0;
  logic        RESET, start_i, flush_i;
  logic [2:0]  funct3_i;
  logic [31:0] srca_i, srcb_i;
  logic [4:0]  rd_i;
  logic        stall_o, busy_o, done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  ex_muldiv_unit dut (
    .CLK(CLK), .RESET(RESET), .start_i(start_i), .flush_i(flush_i),
    .funct3_i(funct3_i), .srca_i(srca_i), .srcb_i(srcb_i), .rd_i(rd_i),
    .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o),
    .result_o(result_o), .rd_o(rd_o)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          done_edge;
    bit          iter;
  } exp_t;
  exp_t q[$];
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd = '0;

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if (f[2] && !f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return 33;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: every non-reset cycle checks handshake outputs and held/new results.
  always @(negedge CLK) begin
    if (!RESET) begin
      bit exp_busy, exp_done;
      exp_busy = (q.size() > 0) && q[0].iter && (cyc < q[0].done_edge);
      exp_done = (q.size() > 0) && (cyc == q[0].done_edge);
      check("busy", busy_o, exp_busy);
      check("done", done_o, exp_done);
      check("stall", stall_o, start_i && !exp_done);
      if (exp_done) begin
        check("result", result_o, q[0].res);
        check("rd", rd_o, q[0].rd);
        $display("op done: result=%h rd=%0d cycle=%0d", result_o, rd_o, cyc);
        last_res = q[0].res;
        last_rd  = q[0].rd;
        void'(q.pop_front());
      end else begin
        check("result_hold", result_o, last_res);
        check("rd_hold", rd_o, last_rd);
        if (q.size() > 0 && cyc > q[0].done_edge) void'(q.pop_front());
      end
    end
  end

  task automatic push_exp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    exp_t e;
    int lat;
    lat = latency(f, a, b);
    e.res = model(f, a, b);
    e.rd = rd;
    e.iter = (lat > 1);
    e.done_edge = cyc + lat - 1;
    q.push_back(e);
  endtask

  // Called at posedge+2; returns at posedge+2 in the IDLE cycle after DONE.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int t;
    start_i = 1'b1; funct3_i = f; srca_i = a; srcb_i = b; rd_i = rd;
    @(posedge CLK); #1;
    push_exp(f, a, b, rd);
    t = 0;
    while (t < 40) begin
      @(negedge CLK);
      if (done_o) break;
      t++;
    end
    if (t >= 40) begin
      total++; bad++;
      $display("FAIL timeout: no done_o for f=%0d a=%h b=%h", f, a, b);
    end
    @(posedge CLK); #2;
    start_i = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    RESET = 1'b1; start_i = 1'b0; flush_i = 1'b0;
    funct3_i = '0; srca_i = '0; srcb_i = '0; rd_i = '0;
    repeat (2) @(posedge CLK);
    #2;
    check("reset_busy", busy_o, 1'b0);
    check("reset_done", done_o, 1'b0);
    check("reset_result", result_o, 32'h0);
    check("reset_rd", rd_o, 5'd0);
    RESET = 1'b0;

    // Hand-computed values pin the reference model itself.
    check("model_mul", model(3'd0, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFEB);
    check("model_mulh", model(3'd1, 32'h80000000, 32'h80000000), 32'h40000000);
    check("model_mulhu", model(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFE);
    check("model_mulhsu", model(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFF);
    check("model_div", model(3'd4, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFD);
    check("model_rem", model(3'd6, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);
    check("model_divu", model(3'd5, 32'd100, 32'd7), 32'd14);
    check("model_remu", model(3'd7, 32'd100, 32'd7), 32'd2);
    check("model_div0", model(3'd4, 32'd5, 32'd0), 32'hFFFFFFFF);
    check("model_ovf_rem", model(3'd6, 32'h80000000, 32'hFFFFFFFF), 32'h0);

    @(posedge CLK); #2;
    issue(3'd0, 32'd7, 32'hFFFFFFFD, 5'd11);
    issue(3'd1, 32'h80000000, 32'h80000000, 5'd1);
    issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2);
    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3);
    issue(3'd4, 32'hFFFFFFF9, 32'd2, 5'd4);
    issue(3'd6, 32'hFFFFFFF9, 32'd2, 5'd5);
    issue(3'd5, 32'd100, 32'd7, 5'd6);
    issue(3'd7, 32'd100, 32'd7, 5'd7);
    issue(3'd4, 32'd5, 32'd0, 5'd8);
    issue(3'd7, 32'd5, 32'd0, 5'd9);
    issue(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd10);
    issue(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12);

    // Flush a DIV during cycle T+10: no done_o, result unchanged.
    start_i = 1'b1; funct3_i = 3'd4; srca_i = 32'd1000; srcb_i = 32'd3; rd_i = 5'd13;
    @(posedge CLK); #1;
    push_exp(3'd4, 32'd1000, 32'd3, 5'd13);
    repeat (9) @(posedge CLK);
    #1;
    flush_i = 1'b1; start_i = 1'b0;
    @(posedge CLK); #1;
    q.delete();
    #1;
    flush_i = 1'b0;
    repeat (4) @(posedge CLK);
    #2;
    $display("flush op: busy=%0d result=%h", busy_o, result_o);

    // Asynchronous reset in cycle T+5 of a MUL clears everything at once.
    start_i = 1'b1; funct3_i = 3'd0; srca_i = 32'd9; srcb_i = 32'd9; rd_i = 5'd14;
    @(posedge CLK); #1;
    push_exp(3'd0, 32'd9, 32'd9, 5'd14);
    repeat (4) @(posedge CLK);
    #2;
    RESET = 1'b1; start_i = 1'b0;
    #1;
    check("rst_mid_busy", busy_o, 1'b0);
    check("rst_mid_done", done_o, 1'b0);
    check("rst_mid_result", result_o, 32'h0);
    check("rst_mid_rd", rd_o, 5'd0);
    q.delete();
    last_res = '0; last_rd = '0;
    $display("reset op: busy=%0d result=%h rd=%0d", busy_o, result_o, rd_o);
    @(posedge CLK); #2;
    RESET = 1'b0;
    @(posedge CLK); #2;
    issue(3'd0, 32'd3, 32'd4, 5'd15);

    for (int i = 0; i < 48; i++) begin
      logic [2:0] f;
      logic [31:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      issue(f, a, b, 5'($urandom_range(0, 31)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge CLK); #2;
      end
    end

    repeat (3) @(posedge CLK);
    #2;
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL pending: %0d results never completed", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
